fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined core: owns the program counter and drives the combinational instruction memory address. It captures the returned instruction word into the IF/ID pipeline register. It handles stall, flush and branch/jump redirect from downstream stages, and tags out-of-range and misaligned fetches so decode can raise exceptions.

Parameters:
IMEM_W, 13, instruction memory byte-address width (memory holds 2**(IMEM_W-2) words)
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
stall_i  input  1  hold PC and IF/ID register
flush_i  input  1  replace IF/ID contents with a bubble; refetch current PC
redirect_i  input  1  load redirect_pc_i into PC (taken branch/jump)
redirect_pc_i  input  32  redirect target byte address
imem_addr_o  output  IMEM_W  byte address to instruction memory
imem_rdata_i  input  32  instruction word from memory (same-cycle combinational)
if_pc_o  output  32  PC of instruction held in IF/ID
if_inst_o  output  32  instruction held in IF/ID
if_valid_o  output  1  IF/ID holds a real instruction
if_fault_o  output  1  IF/ID instruction fetched from PC outside memory range
if_misalign_o  output  1  IF/ID instruction is first after a misaligned redirect
if_count_o  output  32  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (rst_i=1 at clock edge, highest priority): pc_q=RESET_PC, if_pc_o=0, if_inst_o=32'h0000_0013 (NOP), if_valid_o=0, if_fault_o=0, if_misalign_o=0, misalign_pend=0, if_count_o=0. Reset asserted mid-stall or mid-redirect discards everything.
- imem_addr_o = pc_q[IMEM_W-1:0], combinational from pc_q. The memory is combinational, so imem_rdata_i is valid in the same cycle. Fetch-to-IF/ID latency is 1 cycle.
- range_fault = |pc_q[31:IMEM_W], combinational.
- Per-edge priority after reset: redirect_i > flush_i > stall_i > normal advance.
- Redirect:
  - pc_q <= {redirect_pc_i[31:2],2'b00}.
  - misalign_pend <= |redirect_pc_i[1:0]; this overwrites any older pending flag.
  - IF/ID <= bubble (valid=0, inst=NOP, fault=0, misalign=0, pc=0).
  - Overrides stall_i and flush_i in the same cycle.
- Flush (no redirect): IF/ID <= bubble; pc_q and misalign_pend hold. Overrides stall_i.
- Stall (no redirect/flush): pc_q, misalign_pend, IF/ID and if_count_o all hold. imem_addr_o stays constant.
- Normal advance:
  - if_pc_o <= pc_q.
  - if_inst_o <= range_fault ? NOP : imem_rdata_i.
  - if_valid_o <= 1; if_fault_o <= range_fault; if_misalign_o <= misalign_pend.
  - misalign_pend <= 0; if_count_o <= if_count_o+1.
  - pc_q <= pc_q+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- A range-faulted instruction still counts, still advances the PC, and is still valid. Decode owns the trap.
- Bubbles never increment if_count_o. The counter wraps 32'hFFFF_FFFF -> 0.
- No internal FSM beyond the pc_q/misalign_pend registers. There are no combinational paths from stall_i/flush_i/redirect_i to any output.

Test Plan:
- Reset then 4 free-running cycles with imem word n = 32'h1000_0000+n -> imem_addr_o 0,4,8,C. IF/ID shows pc 0,4,8 with matching inst, valid=1. if_count_o=3 after the third load.
- Stall for 3 cycles at pc_q=8 -> imem_addr_o stays 8 and IF/ID is unchanged (pc 4). On release, IF/ID gets pc 8 on the next edge.
- redirect_i with redirect_pc_i=32'h0000_0102 while stall_i=1 -> next cycle pc_q=0x100 and IF/ID is a bubble (valid=0, inst=0x13). The next load has pc 0x100 and if_misalign_o=1. The following load has if_misalign_o=0.
- flush_i alone at pc_q=0x20 -> IF/ID is a bubble, pc_q stays 0x20, and the next load has pc 0x20. flush_i with stall_i together -> flush wins.
- Redirect to 32'h0000_2000 (IMEM_W=13) -> loaded inst=0x13, if_fault_o=1, if_valid_o=1, and pc advances to 0x2004.
- Redirect to 32'hFFFF_FFFC then one advance -> pc_q wraps to 0 and imem_addr_o=0. The faulted instruction at 0xFFFF_FFFC is flagged if_fault_o=1.

Source files
------------

// File: rtl/fetch_stage.sv
// Purpose : instruction-fetch stage; owns the PC, addresses a combinational
//           instruction memory and loads the IF/ID pipeline register.
// Latency : 1 cycle from address presented to instruction visible in IF/ID.
// Backpres: stall_i holds the PC and IF/ID. flush_i inserts a bubble and
//           refetches. redirect_i loads a new PC and inserts a bubble.
// Ports   : clk_i/rst_i (sync, active-high); stall_i, flush_i, redirect_i,
//           redirect_pc_i from downstream; imem_addr_o/imem_rdata_i to memory;
//           if_* outputs are the IF/ID register contents plus a load counter.
module fetch_stage #(
  parameter int          IMEM_W   = 13,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [IMEM_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic              if_valid_o,
  output logic              if_fault_o,
  output logic              if_misalign_o,
  output logic [31:0]       if_count_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q;
  logic        misalign_pend;
  logic        range_fault;

  assign imem_addr_o = pc_q[IMEM_W-1:0];
  // Any set bit above the memory's address range means the fetch is out of range.
  assign range_fault = |pc_q[31:IMEM_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      misalign_pend <= 1'b0;
      if_pc_o       <= 32'h0;
      if_inst_o     <= NOP;
      if_valid_o    <= 1'b0;
      if_fault_o    <= 1'b0;
      if_misalign_o <= 1'b0;
      if_count_o    <= 32'h0;
    end else if (redirect_i) begin
      // Target is forced word aligned; the dropped low bits are remembered so
      // the first instruction fetched there can be tagged for decode.
      pc_q          <= {redirect_pc_i[31:2], 2'b00};
      misalign_pend <= |redirect_pc_i[1:0];
      if_pc_o       <= 32'h0;
      if_inst_o     <= NOP;
      if_valid_o    <= 1'b0;
      if_fault_o    <= 1'b0;
      if_misalign_o <= 1'b0;
    end else if (flush_i) begin
      // Bubble only; the current PC is refetched next cycle.
      if_pc_o       <= 32'h0;
      if_inst_o     <= NOP;
      if_valid_o    <= 1'b0;
      if_fault_o    <= 1'b0;
      if_misalign_o <= 1'b0;
    end else if (!stall_i) begin
      // Out-of-range fetches still load as valid; decode raises the trap.
      if_pc_o       <= pc_q;
      if_inst_o     <= range_fault ? NOP : imem_rdata_i;
      if_valid_o    <= 1'b1;
      if_fault_o    <= range_fault;
      if_misalign_o <= misalign_pend;
      misalign_pend <= 1'b0;
      if_count_o    <= if_count_o + 32'd1;
      pc_q          <= pc_q + 32'd4;
    end
  end

endmodule
